// File: rtl/ad_ip_jesd204_tpl_adc_capture_if.sv
// Link-layer RX beat interface between the JESD204 link layer (master) and the TPL capture stage (slave).
interface ad_ip_jesd204_tpl_adc_capture_if #(
    parameter int NUM_LANES       = 2,
    parameter int OCTETS_PER_BEAT = 4
);
    logic                                   link_valid;
    logic [OCTETS_PER_BEAT-1:0]             link_sof;
    logic [NUM_LANES*8*OCTETS_PER_BEAT-1:0] link_data;
    logic                                   link_ready;

    modport master (output link_valid, link_sof, link_data, input link_ready);
    modport slave  (input link_valid, link_sof, link_data, output link_ready);
endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_capture.sv
// JESD204 ADC transport-layer capture: deframes lane octets into channel samples and gates them
// behind an arm / external-sync / SOF state machine with one-shot length and overflow counting.
module ad_ip_jesd204_tpl_adc_capture #(
    parameter int NUM_LANES       = 2,
    parameter int NUM_CHANNELS    = 2,
    parameter int BITS_PER_SAMPLE = 16,
    parameter int OCTETS_PER_BEAT = 4,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    ad_ip_jesd204_tpl_adc_capture_if.slave         link,
    input  logic [NUM_CHANNELS-1:0]                enable,
    input  logic                                   arm,
    input  logic                                   disarm,
    input  logic                                   oneshot,
    input  logic [LEN_WIDTH-1:0]                   capture_len,
    input  logic                                   ext_sync_en,
    input  logic                                   adc_external_sync,
    input  logic                                   adc_dovf,
    output logic [NUM_CHANNELS-1:0]                adc_valid,
    output logic [NUM_LANES*8*OCTETS_PER_BEAT-1:0] adc_data,
    output logic                                   adc_rst_sync,
    output logic                                   capture_busy,
    output logic                                   capture_done,
    output logic [15:0]                            ovf_count
);
    localparam int LANE_W = 8 * OCTETS_PER_BEAT;
    localparam int DATA_W = NUM_LANES * LANE_W;
    localparam int DPW    = LANE_W / BITS_PER_SAMPLE;
    localparam int OPS    = BITS_PER_SAMPLE / 8;

    typedef enum logic [1:0] {IDLE, ARMED, WAIT_SOF, RUN} state_t;

    state_t                 state, state_nxt;
    logic                   done_nxt;
    logic                   link_ready_q;
    logic                   sync_q;
    logic                   oneshot_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   cnt;
    logic [LEN_WIDTH-1:0]   cnt_inc;
    logic                   arm_go;
    logic                   sync_rise;
    logic                   capture_beat;
    logic                   last_beat;
    logic [NUM_CHANNELS-1:0] vld_p1;
    logic [DATA_W-1:0]      data_p1;

    // Lane octet k sits at bits [k*8 +: 8]; the first octet of each sample becomes its MSB.
    function automatic logic [DATA_W-1:0] deframe(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int l = 0; l < NUM_LANES; l++)
            for (int j = 0; j < DPW; j++)
                for (int b = 0; b < OPS; b++)
                    r[(l*DPW+j)*BITS_PER_SAMPLE + BITS_PER_SAMPLE - 8*(b+1) +: 8] =
                        d[l*LANE_W + (j*OPS+b)*8 +: 8];
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign arm_go       = arm && !disarm;
    assign sync_rise    = adc_external_sync && !sync_q;
    assign cnt_inc      = cnt + 1'b1;
    assign capture_beat = link.link_valid &&
                          ((state == RUN) || (state == WAIT_SOF && link.link_sof[0]));
    assign last_beat    = capture_beat && oneshot_q && (cnt_inc == len_q);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (arm_go) begin
                    if (oneshot && capture_len == '0) done_nxt = 1'b1;
                    else if (ext_sync_en)             state_nxt = ARMED;
                    else                              state_nxt = WAIT_SOF;
                end
            end
            ARMED: begin
                if (disarm)         state_nxt = IDLE;
                else if (sync_rise) state_nxt = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (disarm) state_nxt = IDLE;
                else if (capture_beat) begin
                    state_nxt = last_beat ? IDLE : RUN;
                    done_nxt  = last_beat;
                end
            end
            RUN: begin
                if (disarm) state_nxt = IDLE;
                else if (last_beat) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            link_ready_q <= 1'b0;
            sync_q       <= 1'b0;
            capture_busy <= 1'b0;
            adc_rst_sync <= 1'b0;
            capture_done <= 1'b0;
            ovf_count    <= '0;
            cnt          <= '0;
            oneshot_q    <= 1'b0;
            len_q        <= '0;
            vld_p1       <= '0;
            data_p1      <= '0;
        end else begin
            state        <= state_nxt;
            link_ready_q <= 1'b1;
            sync_q       <= adc_external_sync;
            capture_busy <= (state_nxt != IDLE);
            adc_rst_sync <= (state_nxt == ARMED);
            capture_done <= done_nxt;
            if (state == IDLE && arm_go) begin
                oneshot_q <= oneshot;
                len_q     <= capture_len;
                cnt       <= '0;
                ovf_count <= '0;
            end else begin
                if (capture_beat)                cnt       <= cnt_inc;
                if (state == RUN && adc_dovf)    ovf_count <= sat_inc(ovf_count);
            end
            // Stage p1: deframed beat and its per-channel valid
            vld_p1 <= capture_beat ? enable : '0;
            if (link.link_valid) data_p1 <= deframe(link.link_data);
        end
    end

    assign link.link_ready = link_ready_q;
    assign adc_valid       = vld_p1;
    assign adc_data        = data_p1;
endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_capture.sv
// Directed, table-driven bench for the JESD204 ADC capture stage (2 lanes, 16-bit samples, 4 octets/beat).
module tb_ad_ip_jesd204_tpl_adc_capture;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  enable;
    logic        arm, disarm, oneshot, ext_sync_en, adc_external_sync, adc_dovf;
    logic [15:0] capture_len;
    logic [1:0]  adc_valid;
    logic [63:0] adc_data;
    logic        adc_rst_sync, capture_busy, capture_done;
    logic [15:0] ovf_count;

    int checks = 0;
    int errors = 0;

    ad_ip_jesd204_tpl_adc_capture_if #(.NUM_LANES(2), .OCTETS_PER_BEAT(4)) link_if ();

    ad_ip_jesd204_tpl_adc_capture #(
        .NUM_LANES(2), .NUM_CHANNELS(2), .BITS_PER_SAMPLE(16), .OCTETS_PER_BEAT(4), .LEN_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .link(link_if), .enable(enable), .arm(arm), .disarm(disarm),
        .oneshot(oneshot), .capture_len(capture_len), .ext_sync_en(ext_sync_en),
        .adc_external_sync(adc_external_sync), .adc_dovf(adc_dovf), .adc_valid(adc_valid),
        .adc_data(adc_data), .adc_rst_sync(adc_rst_sync), .capture_busy(capture_busy),
        .capture_done(capture_done), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  en;
        logic        valid;
        logic [63:0] data;
        logic [1:0]  exp_valid;
        logic [63:0] exp_data;
    } vec_t;

    vec_t tbl[6];

    // lane0 octets 12 34 56 78, lane1 octets AA BB CC DD
    localparam logic [63:0] V1 = 64'hDDCCBBAA_78563412, E1 = 64'hCCDDAABB_56781234;
    localparam logic [63:0] V2 = 64'h7F8000FF_03020100, E2 = 64'h807FFF00_02030001;
    localparam logic [63:0] V4 = 64'hEFCDAB89_67452301, E4 = 64'hCDEF89AB_45670123;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic beat(input logic v, input logic [3:0] sof, input logic [63:0] d);
        link_if.link_valid = v;
        link_if.link_sof   = sof;
        link_if.link_data  = d;
    endtask

    task automatic do_arm(input logic os, input logic [15:0] len, input logic es);
        arm = 1'b1; oneshot = os; capture_len = len; ext_sync_en = es;
        step();
        arm = 1'b0;
    endtask

    task automatic do_disarm();
        beat(1'b0, 4'b0, 64'h0);
        disarm = 1'b1;
        step();
        disarm = 1'b0;
    endtask

    initial begin
        int nvalid, ndone, done_at, valid5_at;
        logic [7:0] vpat;

        reset = 1'b1; enable = 2'b11; arm = 1'b0; disarm = 1'b0; oneshot = 1'b0;
        capture_len = 16'd0; ext_sync_en = 1'b0; adc_external_sync = 1'b0; adc_dovf = 1'b0;
        beat(1'b0, 4'b0, 64'h0);

        tbl[0] = '{2'b11, 1'b1, V2,                    2'b11, E2};
        tbl[1] = '{2'b11, 1'b0, 64'hDEADBEEF_DEADBEEF, 2'b00, E2};
        tbl[2] = '{2'b01, 1'b1, V4,                    2'b01, E4};
        tbl[3] = '{2'b10, 1'b1, {64{1'b1}},            2'b10, {64{1'b1}}};
        tbl[4] = '{2'b00, 1'b1, V1,                    2'b00, E1};
        tbl[5] = '{2'b11, 1'b1, 64'h0,                 2'b11, 64'h0};

        // Reset values
        step(); step();
        chk("rst_link_ready", link_if.link_ready, 0);
        chk("rst_adc_valid", adc_valid, 0);
        chk("rst_adc_data", adc_data, 0);
        chk("rst_rst_sync", adc_rst_sync, 0);
        chk("rst_busy", capture_busy, 0);
        chk("rst_done", capture_done, 0);
        chk("rst_ovf", ovf_count, 0);
        reset = 1'b0;
        step();
        chk("link_ready_after_rst", link_if.link_ready, 1);

        // 1. Continuous capture, SOF at beat 3
        do_arm(1'b0, 16'd0, 1'b0);
        chk("t1_busy", capture_busy, 1);
        chk("t1_rst_sync", adc_rst_sync, 0);
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, (i == 1) ? 4'b0010 : 4'b0000, V4);
            step();
            chk("t1_pre_sof_valid", adc_valid, 0);
        end
        beat(1'b1, 4'b0001, V1);
        step();
        chk("t1_sof_valid", adc_valid, 2'b11);
        chk("t1_sof_data", adc_data, E1);
        for (int i = 0; i < 6; i++) begin
            enable = tbl[i].en;
            beat(tbl[i].valid, 4'b0, tbl[i].data);
            step();
            chk($sformatf("tbl%0d_valid", i), adc_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_data", i), adc_data, tbl[i].exp_data);
        end
        enable = 2'b11;

        // 5a. disarm mid-RUN
        do_disarm();
        chk("t5_disarm_busy", capture_busy, 0);
        chk("t5_disarm_done", capture_done, 0);
        chk("t5_disarm_valid", adc_valid, 0);

        // 2. One-shot of 5 beats with link_valid gaps
        do_arm(1'b1, 16'd5, 1'b0);
        vpat = 8'b1100_1101;
        nvalid = 0; ndone = 0; done_at = -1; valid5_at = -1;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) beat(vpat[c], (c == 0) ? 4'b0001 : 4'b0000, V2);
            else       beat(1'b1, 4'b0001, V2);
            step();
            if (adc_valid != 2'b00) begin
                nvalid++;
                if (nvalid == 5) valid5_at = c;
            end
            if (capture_done) begin
                ndone++;
                done_at = c;
                chk("t2_busy_at_done", capture_busy, 0);
            end
        end
        chk("t2_valid_count", nvalid, 5);
        chk("t2_done_count", ndone, 1);
        chk("t2_done_with_5th", done_at, valid5_at);

        // Re-arm with arm held through completion (one-shot of 1 from WAIT_SOF)
        beat(1'b0, 4'b0, 64'h0);
        arm = 1'b1; oneshot = 1'b1; capture_len = 16'd1; ext_sync_en = 1'b0;
        step();
        chk("rearm_busy0", capture_busy, 1);
        beat(1'b1, 4'b0001, V1);
        step();
        beat(1'b0, 4'b0, 64'h0);
        chk("len1_done", capture_done, 1);
        chk("len1_valid", adc_valid, 2'b11);
        chk("len1_busy", capture_busy, 0);
        step();
        chk("rearm_busy1", capture_busy, 1);
        chk("rearm_done_clear", capture_done, 0);
        arm = 1'b0;
        do_disarm();
        chk("rearm_disarm", capture_busy, 0);

        // 3. External sync already high at arm
        adc_external_sync = 1'b1;
        step();
        do_arm(1'b0, 16'd0, 1'b1);
        chk("t3_armed_rst_sync", adc_rst_sync, 1);
        chk("t3_armed_busy", capture_busy, 1);
        step(); step(); step();
        chk("t3_level_no_edge", adc_rst_sync, 1);
        adc_external_sync = 1'b0;
        step();
        chk("t3_sync_low", adc_rst_sync, 1);
        adc_external_sync = 1'b1;
        step();
        chk("t3_edge_rst_sync", adc_rst_sync, 0);
        chk("t3_edge_busy", capture_busy, 1);
        beat(1'b1, 4'b0000, V1);
        step();
        chk("t3_wait_sof_valid", adc_valid, 0);
        do_disarm();
        chk("t3_disarm", capture_busy, 0);
        adc_external_sync = 1'b0;

        // 4. Overflow counting
        do_arm(1'b0, 16'd0, 1'b0);
        adc_dovf = 1'b1;
        step();
        adc_dovf = 1'b0;
        chk("t4_no_count_wait_sof", ovf_count, 0);
        beat(1'b1, 4'b0001, V1);
        step();
        beat(1'b0, 4'b0, 64'h0);
        adc_dovf = 1'b1;
        step(); step(); step();
        adc_dovf = 1'b0;
        chk("t4_ovf3", ovf_count, 3);
        do_disarm();
        step();
        chk("t4_ovf_hold_idle", ovf_count, 3);
        do_arm(1'b0, 16'd0, 1'b0);
        chk("t4_ovf_clear", ovf_count, 0);
        beat(1'b1, 4'b0001, V1);
        step();
        beat(1'b0, 4'b0, 64'h0);
        adc_dovf = 1'b1;
        for (int i = 0; i < 65534; i++) step();
        chk("t4_ovf_fffe", ovf_count, 16'hFFFE);
        step();
        chk("t4_ovf_ffff", ovf_count, 16'hFFFF);
        step(); step();
        chk("t4_ovf_sat", ovf_count, 16'hFFFF);
        adc_dovf = 1'b0;
        do_disarm();
        do_arm(1'b0, 16'd0, 1'b0);
        chk("t4_ovf_rearm_clear", ovf_count, 0);
        do_disarm();

        // 5b. arm and disarm together, then zero-length one-shot
        arm = 1'b1; disarm = 1'b1;
        step();
        arm = 1'b0; disarm = 1'b0;
        chk("t5_arm_disarm_busy", capture_busy, 0);
        chk("t5_arm_disarm_done", capture_done, 0);
        beat(1'b1, 4'b0001, V1);
        do_arm(1'b1, 16'd0, 1'b0);
        chk("t5_len0_done", capture_done, 1);
        chk("t5_len0_busy", capture_busy, 0);
        chk("t5_len0_valid", adc_valid, 0);
        step();
        chk("t5_len0_done_pulse", capture_done, 0);
        chk("t5_len0_no_valid", adc_valid, 0);

        // 6. Reset mid-RUN
        beat(1'b0, 4'b0, 64'h0);
        do_arm(1'b0, 16'd0, 1'b0);
        beat(1'b1, 4'b0001, V1);
        adc_dovf = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        chk("t6_rst_valid", adc_valid, 0);
        chk("t6_rst_data", adc_data, 0);
        chk("t6_rst_busy", capture_busy, 0);
        chk("t6_rst_ovf", ovf_count, 0);
        chk("t6_rst_done", capture_done, 0);
        chk("t6_rst_ready", link_if.link_ready, 0);
        reset = 1'b0;
        adc_dovf = 1'b0;
        beat(1'b0, 4'b0, 64'h0);
        step();
        chk("t6_ready_after", link_if.link_ready, 1);
        chk("t6_idle_after", capture_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
